alu_seq_unit: RTL and testbench

Registered, handshaked successor to the combinational ALU. It takes one operand pair per transaction over a valid/ready interface and executes single-cycle logic, arithmetic and shift ops in one clock. Unsigned multiply and divide run as iterative multi-cycle ops. It returns a result, a high/remainder word and a flag vector, and sits between the decode/issue stage and writeback of the MIPS datapath.

---
 rtl/alu_seq_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered, handshaked ALU for the MIPS datapath.
// Single-cycle ops (logic, add/sub, shifts, rotates, compares) complete one
// cycle after accept. MUL (unsigned shift-add) and DIVU (restoring) iterate
// one bit per cycle for ALU_SIZE cycles before the result is presented.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   alu_in_valid/alu_in_ready   operand handshake (accept = valid & ready)
//   alu_in_a, alu_in_b, alu_sel operands and opcode (B low bits = shamt)
//   alu_out_valid/alu_out_ready result handshake
//   alu_out, alu_out_hi         result, MUL high half / DIVU remainder
//   carry_out, zero_out, neg_out, ovf_out, div_zero_out   flags
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no result held, ready for a new transaction
// EXEC  | MUL/DIVU iterating, down-counter r_cnt to terminal count 0
// DONE  | result valid and held until alu_out_ready
module alu_seq_unit #(
  parameter  int ALU_SIZE = 8,
  localparam int SHAMT_W  = $clog2(ALU_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_in_valid,
  output logic                alu_in_ready,
  input  logic [ALU_SIZE-1:0] alu_in_a,
  input  logic [ALU_SIZE-1:0] alu_in_b,
  input  logic [3:0]          alu_sel,
  output logic                alu_out_valid,
  input  logic                alu_out_ready,
  output logic [ALU_SIZE-1:0] alu_out,
  output logic [ALU_SIZE-1:0] alu_out_hi,
  output logic                carry_out,
  output logic                zero_out,
  output logic                neg_out,
  output logic                ovf_out,
  output logic                div_zero_out
);

  localparam int MSB = ALU_SIZE - 1;

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_DIVU = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4,  OP_SRL  = 4'd5,  OP_ROL  = 4'd6,  OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8,  OP_OR   = 4'd9,  OP_XOR  = 4'd10, OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12, OP_XNOR = 4'd13, OP_SLT  = 4'd14, OP_SEQ  = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [SHAMT_W-1:0]  r_cnt;
  logic [ALU_SIZE-1:0] r_hi, r_lo, r_opd;
  logic                r_is_div;
  logic [ALU_SIZE-1:0] r_out, r_out_hi;
  logic                r_carry, r_zero, r_neg, r_ovf, r_dz;

  logic                w_in_ready, w_out_valid, w_accept, w_is_iter;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_is_iter ? S_EXEC : S_DONE;
      S_EXEC: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: begin
        if (alu_out_ready) begin
          if (w_accept) w_state_nxt = w_is_iter ? S_EXEC : S_DONE;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & alu_out_ready);
    w_out_valid = (r_state == S_DONE);
  end

  assign w_accept  = alu_in_valid & w_in_ready;
  assign w_is_iter = (alu_sel == OP_MUL) | (alu_sel == OP_DIVU);

  // ---------------- single-cycle datapath ----------------
  logic [SHAMT_W-1:0]  w_shamt, w_shamt_neg;
  logic [ALU_SIZE:0]   w_add, w_sub, w_sll_ext, w_srl_ext;
  logic [ALU_SIZE-1:0] w_res;
  logic                w_carry, w_ovf;

  assign w_shamt     = alu_in_b[SHAMT_W-1:0];
  // (ALU_SIZE - shamt) mod ALU_SIZE; shamt 0 makes both rotate halves equal to A.
  assign w_shamt_neg = -w_shamt;
  assign w_add       = {1'b0, alu_in_a} + {1'b0, alu_in_b};
  assign w_sub       = {1'b0, alu_in_a} - {1'b0, alu_in_b};
  // One guard bit on the exit side catches the last bit shifted out.
  assign w_sll_ext   = {1'b0, alu_in_a} << w_shamt;
  assign w_srl_ext   = {alu_in_a, 1'b0} >> w_shamt;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        w_res   = w_add[MSB:0];
        w_carry = w_add[ALU_SIZE];
        w_ovf   = (alu_in_a[MSB] == alu_in_b[MSB]) & (w_add[MSB] != alu_in_a[MSB]);
      end
      OP_SUB: begin
        w_res   = w_sub[MSB:0];
        w_carry = w_sub[ALU_SIZE];
        w_ovf   = (alu_in_a[MSB] != alu_in_b[MSB]) & (w_sub[MSB] != alu_in_a[MSB]);
      end
      OP_MUL, OP_DIVU: w_res = '0;
      OP_SLL: begin
        w_res   = w_sll_ext[MSB:0];
        w_carry = w_sll_ext[ALU_SIZE];
      end
      OP_SRL: begin
        w_res   = w_srl_ext[ALU_SIZE:1];
        w_carry = w_srl_ext[0];
      end
      OP_ROL:  w_res = (alu_in_a << w_shamt) | (alu_in_a >> w_shamt_neg);
      OP_ROR:  w_res = (alu_in_a >> w_shamt) | (alu_in_a << w_shamt_neg);
      OP_AND:  w_res = alu_in_a & alu_in_b;
      OP_OR:   w_res = alu_in_a | alu_in_b;
      OP_XOR:  w_res = alu_in_a ^ alu_in_b;
      OP_NOR:  w_res = ~(alu_in_a | alu_in_b);
      OP_NAND: w_res = ~(alu_in_a & alu_in_b);
      OP_XNOR: w_res = ~(alu_in_a ^ alu_in_b);
      OP_SLT:  w_res = {{(ALU_SIZE-1){1'b0}}, ($signed(alu_in_a) < $signed(alu_in_b))};
      OP_SEQ:  w_res = {{(ALU_SIZE-1){1'b0}}, (alu_in_a == alu_in_b)};
    endcase
  end

  // ---------------- iterative datapath ----------------
  // MUL: {r_hi, r_lo} starts as {0, B}, adds A into r_hi when r_lo[0] is set,
  // then shifts right. DIVU: r_lo starts as A (becomes quotient), r_hi is the
  // partial remainder. With B == 0 every trial subtract succeeds, so the
  // quotient saturates to all ones and the remainder ends up equal to A.
  logic [ALU_SIZE:0]   w_mul_sum, w_div_sh;
  logic [ALU_SIZE-1:0] w_div_diff, w_it_hi, w_it_lo;
  logic                w_div_ge;

  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
  assign w_div_sh   = {r_hi, r_lo[MSB]};
  assign w_div_ge   = w_div_sh >= {1'b0, r_opd};
  assign w_div_diff = w_div_sh[MSB:0] - r_opd;

  always_comb begin
    if (r_is_div) begin
      w_it_hi = w_div_ge ? w_div_diff : w_div_sh[MSB:0];
      w_it_lo = {r_lo[MSB-1:0], w_div_ge};
    end else begin
      w_it_hi = w_mul_sum[ALU_SIZE:1];
      w_it_lo = {w_mul_sum[0], r_lo[MSB:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opd    <= '0;
      r_is_div <= 1'b0;
      r_out    <= '0;
      r_out_hi <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      if (w_is_iter) begin
        r_hi     <= '0;
        r_lo     <= (alu_sel == OP_MUL) ? alu_in_b : alu_in_a;
        r_opd    <= (alu_sel == OP_MUL) ? alu_in_a : alu_in_b;
        r_is_div <= (alu_sel == OP_DIVU);
        r_cnt    <= SHAMT_W'(ALU_SIZE - 1);
      end else begin
        r_out    <= w_res;
        r_out_hi <= '0;
        r_carry  <= w_carry;
        r_zero   <= (w_res == '0);
        r_neg    <= w_res[MSB];
        r_ovf    <= w_ovf;
        r_dz     <= 1'b0;
      end
    end else if (r_state == S_EXEC) begin
      r_hi <= w_it_hi;
      r_lo <= w_it_lo;
      if (r_cnt == '0) begin
        r_out    <= w_it_lo;
        r_out_hi <= w_it_hi;
        r_carry  <= 1'b0;
        r_zero   <= (w_it_lo == '0);
        r_neg    <= w_it_lo[MSB];
        r_ovf    <= 1'b0;
        r_dz     <= r_is_div & (r_opd == '0);
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign alu_in_ready  = w_in_ready;
  assign alu_out_valid = w_out_valid;
  assign alu_out       = r_out;
  assign alu_out_hi    = r_out_hi;
  assign carry_out     = r_carry;
  assign zero_out      = r_zero;
  assign neg_out       = r_neg;
  assign ovf_out       = r_ovf;
  assign div_zero_out  = r_dz;

endmodule

// File: tb/tb_alu_seq_unit.sv
`timescale 1ns/1ps
// Testbench for alu_seq_unit (ALU_SIZE = 8): scoreboard of expected results
// built from an independent reference model, compared as the DUT presents them.
module tb_alu_seq_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         alu_in_valid;
  logic         alu_in_ready;
  logic [W-1:0] alu_in_a, alu_in_b;
  logic [3:0]   alu_sel;
  logic         alu_out_valid;
  logic         alu_out_ready;
  logic [W-1:0] alu_out, alu_out_hi;
  logic         carry_out, zero_out, neg_out, ovf_out, div_zero_out;

  alu_seq_unit #(.ALU_SIZE(W)) dut (
    .clk(clk), .rst(rst),
    .alu_in_valid(alu_in_valid), .alu_in_ready(alu_in_ready),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_sel(alu_sel),
    .alu_out_valid(alu_out_valid), .alu_out_ready(alu_out_ready),
    .alu_out(alu_out), .alu_out_hi(alu_out_hi),
    .carry_out(carry_out), .zero_out(zero_out), .neg_out(neg_out),
    .ovf_out(ovf_out), .div_zero_out(div_zero_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       n;
    logic       o;
    logic       dz;
  } res_t;

  typedef struct {
    res_t r;
    int   lat;
    int   acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    int         sa, sb, s, sh;
    logic [15:0] p;
    logic [7:0] r, hi;
    logic       c, o, dz;
    res_t       res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[2:0]);
    r = 8'h00; hi = 8'h00; c = 1'b0; o = 1'b0; dz = 1'b0;
    case (sel)
      4'd0: begin s = int'(a) + int'(b); r = 8'(s); c = (s > 255); o = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin s = int'(a) - int'(b); r = 8'(s); c = (a < b); o = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: begin p = 16'(a) * 16'(b); r = p[7:0]; hi = p[15:8]; end
      4'd3: begin
        if (b == 8'h00) begin r = 8'hFF; hi = a; dz = 1'b1; end
        else begin r = a / b; hi = a % b; end
      end
      4'd4: begin r = a; for (int i = 0; i < sh; i++) begin c = r[7]; r = {r[6:0], 1'b0}; end end
      4'd5: begin r = a; for (int i = 0; i < sh; i++) begin c = r[0]; r = {1'b0, r[7:1]}; end end
      4'd6: begin r = a; for (int i = 0; i < sh; i++) r = {r[6:0], r[7]}; end
      4'd7: begin r = a; for (int i = 0; i < sh; i++) r = {r[0], r[7:1]}; end
      4'd8:  r = a & b;
      4'd9:  r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~(a | b);
      4'd12: r = ~(a & b);
      4'd13: r = ~(a ^ b);
      4'd14: r = (sa < sb) ? 8'h01 : 8'h00;
      4'd15: r = (a == b) ? 8'h01 : 8'h00;
    endcase
    res.out = r; res.hi = hi; res.c = c; res.z = (r == 8'h00); res.n = r[7]; res.o = o; res.dz = dz;
    return res;
  endfunction

  function automatic res_t dut_res();
    return {alu_out, alu_out_hi, carry_out, zero_out, neg_out, ovf_out, div_zero_out};
  endfunction

  function automatic int op_lat(input logic [3:0] sel);
    return (sel == 4'd2 || sel == 4'd3) ? W + 1 : 1;
  endfunction

  task automatic test_reset;
    rst = 1'b1; alu_in_valid = 1'b0; alu_out_ready = 1'b1;
    alu_in_a = '0; alu_in_b = '0; alu_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (alu_out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", alu_out_valid);
    else n_pass++;
    n_total++;
    if (alu_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", alu_in_ready);
    else n_pass++;
    n_total++;
    if (dut_res() !== '0) $display("FAIL reset_outputs: got %h expected 0", dut_res());
    else n_pass++;
  endtask

  // One transaction from IDLE; inputs are scrambled right after accept.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel, input string name);
    exp_t e;
    bit   seen;
    @(negedge clk);
    n_total++;
    if (alu_in_ready !== 1'b1) $display("FAIL %s_in_ready: got %b expected 1", name, alu_in_ready);
    else n_pass++;
    alu_in_a = a; alu_in_b = b; alu_sel = sel; alu_in_valid = 1'b1;
    e.r = model(a, b, sel); e.lat = op_lat(sel); e.acc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    alu_in_valid = 1'b0;
    alu_in_a = 8'($urandom); alu_in_b = 8'($urandom); alu_sel = 4'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (alu_out_valid) seen = 1'b1;
    end
    e = sb_q.pop_front();
    n_total++;
    if (!seen) begin
      $display("FAIL %s_timeout: got no alu_out_valid expected one within 40 cycles", name);
    end else begin
      n_pass++;
      n_total++;
      if (cyc - e.acc !== e.lat) $display("FAIL %s_latency: got %0d expected %0d", name, cyc - e.acc, e.lat);
      else n_pass++;
      n_total++;
      if (dut_res() !== e.r) $display("FAIL %s_result: got %h expected %h", name, dut_res(), e.r);
      else n_pass++;
    end
  endtask

  task automatic test_directed;
    do_op(8'h0A, 8'h02, 4'd0,  "add_basic");
    do_op(8'hF6, 8'h0A, 4'd0,  "add_carry_zero");
    do_op(8'h80, 8'h01, 4'd1,  "sub_ovf");
    do_op(8'h02, 8'h0A, 4'd1,  "sub_borrow");
    do_op(8'hF6, 8'h0A, 4'd14, "slt_signed");
    do_op(8'hF6, 8'h0A, 4'd2,  "mul");
    do_op(8'hF6, 8'h0A, 4'd3,  "divu");
    do_op(8'h55, 8'h00, 4'd3,  "divu_by_zero");
    do_op(8'h81, 8'hF9, 4'd4,  "sll_upper_b_ignored");
    do_op(8'h81, 8'h08, 4'd5,  "srl_shamt_zero");
    do_op(8'h81, 8'h07, 4'd5,  "srl_max");
    do_op(8'h81, 8'h03, 4'd6,  "rol");
    do_op(8'h81, 8'h0B, 4'd7,  "ror");
    do_op(8'h5A, 8'h5A, 4'd15, "seq_equal");
    do_op(8'hFF, 8'h7F, 4'd0,  "add_neg_no_ovf");
  endtask

  // Every opcode issued as fast as in_ready allows, with alu_out_ready high.
  task automatic test_back_to_back;
    exp_t e;
    int   idx, first, last;
    idx = 0; first = -1; last = -1;
    alu_out_ready = 1'b1;
    for (int k = 0; k < 200 && (idx < 16 || sb_q.size() > 0); k++) begin
      @(negedge clk);
      if (alu_out_valid) begin
        last = cyc;
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL b2b_unexpected: got result %h expected none", dut_res());
        end else begin
          e = sb_q.pop_front();
          if (dut_res() !== e.r) $display("FAIL b2b_result: got %h expected %h", dut_res(), e.r);
          else n_pass++;
          n_total++;
          if (cyc - e.acc !== e.lat) $display("FAIL b2b_latency: got %0d expected %0d", cyc - e.acc, e.lat);
          else n_pass++;
        end
      end
      if (idx < 16 && alu_in_ready) begin
        alu_in_a = 8'h0A; alu_in_b = 8'h02; alu_sel = 4'(idx); alu_in_valid = 1'b1;
        e.r = model(8'h0A, 8'h02, 4'(idx)); e.lat = op_lat(4'(idx)); e.acc = cyc;
        sb_q.push_back(e);
        if (idx == 0) first = cyc;
        idx++;
      end else begin
        alu_in_valid = 1'b0;
      end
    end
    alu_in_valid = 1'b0;
    n_total++;
    if (idx != 16 || sb_q.size() != 0) begin
      $display("FAIL b2b_complete: got %0d issued %0d pending expected 16 issued 0 pending", idx, sb_q.size());
      sb_q.delete();
    end else n_pass++;
    // 14 single-cycle ops at one per cycle plus two 9-cycle iterative ops.
    n_total++;
    if (last - first !== 32) $display("FAIL b2b_total_cycles: got %0d expected 32", last - first);
    else n_pass++;
  endtask

  task automatic test_stall;
    exp_t ex, ey;
    @(negedge clk);
    alu_out_ready = 1'b0;
    alu_in_a = 8'h3C; alu_in_b = 8'h0F; alu_sel = 4'd10; alu_in_valid = 1'b1;
    ex.r = model(8'h3C, 8'h0F, 4'd10); ex.lat = 1; ex.acc = cyc;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    alu_in_a = 8'h02; alu_in_b = 8'h0A; alu_sel = 4'd1;
    ex = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (alu_out_valid !== 1'b1) $display("FAIL stall_valid_c%0d: got %b expected 1", i, alu_out_valid);
      else n_pass++;
      n_total++;
      if (dut_res() !== ex.r) $display("FAIL stall_hold_c%0d: got %h expected %h", i, dut_res(), ex.r);
      else n_pass++;
      n_total++;
      if (alu_in_ready !== 1'b0) $display("FAIL stall_in_ready_c%0d: got %b expected 0", i, alu_in_ready);
      else n_pass++;
    end
    alu_out_ready = 1'b1;
    ey.r = model(8'h02, 8'h0A, 4'd1); ey.lat = 1; ey.acc = cyc;
    sb_q.push_back(ey);
    #1;
    n_total++;
    if (alu_in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b expected 1", alu_in_ready);
    else n_pass++;
    @(posedge clk);
    #1 alu_in_valid = 1'b0;
    @(negedge clk);
    ey = sb_q.pop_front();
    n_total++;
    if (alu_out_valid !== 1'b1 || cyc - ey.acc !== 1)
      $display("FAIL stall_handoff: got valid %b latency %0d expected valid 1 latency 1", alu_out_valid, cyc - ey.acc);
    else n_pass++;
    n_total++;
    if (dut_res() !== ey.r) $display("FAIL stall_handoff_result: got %h expected %h", dut_res(), ey.r);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    int stale;
    @(negedge clk);
    alu_out_ready = 1'b1;
    alu_in_a = 8'hF6; alu_in_b = 8'h0A; alu_sel = 4'd2; alu_in_valid = 1'b1;
    @(posedge clk);
    #1 alu_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (alu_out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", alu_out_valid);
    else n_pass++;
    n_total++;
    if (dut_res() !== '0) $display("FAIL midrst_outputs: got %h expected 0", dut_res());
    else n_pass++;
    n_total++;
    if (alu_in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", alu_in_ready);
    else n_pass++;
    do_op(8'h33, 8'h44, 4'd0, "post_reset_add");
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (alu_out_valid) stale++;
    end
    n_total++;
    if (stale !== 0) $display("FAIL midrst_stale: got %0d extra valid cycles expected 0", stale);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_stall;
    test_reset_mid_op;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
